vga_sync_gen: RTL

Parametrised VGA raster timing generator: a pixel-clock prescaler plus horizontal and vertical counters. From these it produces sync pulses, active-video, and line/frame strobes for any resolution and polarity. It is the successor to the fixed 640-wide horizontal counter and sits between the system clock and the pixel/character renderers. It adds a vertical axis, programmable porches and sync widths, sync polarity, and a frame strobe.

---
 rtl/vga_sync_gen_pkg.sv | 26 ++
 rtl/vga_sync_gen_if.sv | 23 ++
 rtl/vga_axis_counter.sv | 58 +++++
 rtl/vga_sync_gen.sv | 103 ++++++++++
 4 files changed

// File: rtl/vga_sync_gen_pkg.sv
// Shared VGA timing definitions: per-axis timing record, standard mode constants
// and a helper for the total period of an axis.
package vga_timing_pkg;

    typedef struct packed {
        logic [15:0] active;
        logic [15:0] fp;
        logic [15:0] sync;
        logic [15:0] bp;
        logic        pol;
    } vga_axis_t;

    localparam vga_axis_t VGA_640X480_60_H =
        '{active: 16'd640, fp: 16'd16, sync: 16'd96, bp: 16'd48, pol: 1'b0};
    localparam vga_axis_t VGA_640X480_60_V =
        '{active: 16'd480, fp: 16'd10, sync: 16'd2, bp: 16'd33, pol: 1'b0};
    localparam vga_axis_t VGA_800X600_72_H =
        '{active: 16'd800, fp: 16'd56, sync: 16'd120, bp: 16'd64, pol: 1'b1};
    localparam vga_axis_t VGA_800X600_72_V =
        '{active: 16'd600, fp: 16'd37, sync: 16'd6, bp: 16'd23, pol: 1'b1};

    function automatic int unsigned axis_total(input vga_axis_t a);
        return 32'(a.active) + 32'(a.fp) + 32'(a.sync) + 32'(a.bp);
    endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Raster timing bundle produced by vga_sync_gen and consumed by the pixel renderers.
interface vga_sync_gen_if #(
    parameter int CNT_W = 10
);
    logic [CNT_W-1:0] cntHorizontal;
    logic [CNT_W-1:0] cntVertical;
    logic             pix_tick;
    logic             hsync;
    logic             vsync;
    logic             video_on;
    logic             line_end;
    logic             frame_end;

    modport master (
        output cntHorizontal, cntVertical, pix_tick, hsync, vsync,
               video_on, line_end, frame_end
    );

    modport slave (
        input  cntHorizontal, cntVertical, pix_tick, hsync, vsync,
               video_on, line_end, frame_end
    );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter, registered sync decode and
// combinational active/wrap decodes.
module vga_axis_counter #(
    parameter int CNT_W  = 10,
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter bit POL    = 1'b0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             advance,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output logic             sync_q,
    output logic             active
);
    localparam int TOTAL = ACTIVE + FP + SYNC + BP;
    localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] SYNC_FIRST = CNT_W'(ACTIVE + FP);
    localparam logic [CNT_W-1:0] SYNC_LAST  = CNT_W'(ACTIVE + FP + SYNC - 1);
    localparam logic [CNT_W-1:0] ACTIVE_END = CNT_W'(ACTIVE);

    if (SYNC < 1) begin : g_bad_sync
        $error("vga_axis_counter: SYNC must be at least 1");
    end

    logic [CNT_W-1:0] count_reg, count_next;
    logic             sync_reg, sync_next;
    logic             last;

    always_comb begin
        last       = (count_reg == LAST);
        count_next = count_reg;
        if (advance) begin
            count_next = last ? '0 : count_reg + 1'b1;
        end
        // Decoded from the current count, so sync lags the counter by one Clk.
        sync_next = ((count_reg >= SYNC_FIRST) && (count_reg <= SYNC_LAST)) ? POL : ~POL;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            count_reg <= '0;
            sync_reg  <= ~POL;
        end else begin
            count_reg <= count_next;
            sync_reg  <= sync_next;
        end
    end

    assign count  = count_reg;
    assign sync_q = sync_reg;
    assign wrap   = last && advance;
    assign active = (count_reg < ACTIVE_END);

endmodule

// File: rtl/vga_sync_gen.sv
// Parametrised VGA raster timing generator: pixel prescaler, chained horizontal
// and vertical axis counters, registered video_on and line/frame strobes.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int CNT_W    = 10,
    parameter int H_ACTIVE = int'(VGA_640X480_60_H.active),
    parameter int H_FP     = int'(VGA_640X480_60_H.fp),
    parameter int H_SYNC   = int'(VGA_640X480_60_H.sync),
    parameter int H_BP     = int'(VGA_640X480_60_H.bp),
    parameter int V_ACTIVE = int'(VGA_640X480_60_V.active),
    parameter int V_FP     = int'(VGA_640X480_60_V.fp),
    parameter int V_SYNC   = int'(VGA_640X480_60_V.sync),
    parameter int V_BP     = int'(VGA_640X480_60_V.bp),
    parameter bit HS_POL   = VGA_640X480_60_H.pol,
    parameter bit VS_POL   = VGA_640X480_60_V.pol
) (
    input  logic           Clk,
    input  logic           Reset,
    vga_sync_gen_if.master vga
);
    localparam vga_axis_t H_CFG = '{active: 16'(H_ACTIVE), fp: 16'(H_FP),
                                    sync: 16'(H_SYNC), bp: 16'(H_BP), pol: HS_POL};
    localparam vga_axis_t V_CFG = '{active: 16'(V_ACTIVE), fp: 16'(V_FP),
                                    sync: 16'(V_SYNC), bp: 16'(V_BP), pol: VS_POL};

    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_sync_gen: CLK_DIV must be at least 1");
    end
    if (axis_total(H_CFG) > (32'd1 << CNT_W)) begin : g_bad_htotal
        $error("vga_sync_gen: H_TOTAL exceeds 2**CNT_W");
    end
    if (axis_total(V_CFG) > (32'd1 << CNT_W)) begin : g_bad_vtotal
        $error("vga_sync_gen: V_TOTAL exceeds 2**CNT_W");
    end

    // A one-bit prescaler that never leaves 0 gives a constant pix_tick at CLK_DIV = 1.
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0]    presc_reg, presc_next;
    logic             pix_tick;
    logic [CNT_W-1:0] h_count, v_count;
    logic             h_wrap, v_wrap;
    logic             h_sync_q, v_sync_q;
    logic             h_active, v_active;
    logic             video_on_reg, line_end_reg, frame_end_reg;

    assign pix_tick = (presc_reg == PRE_LAST);

    always_comb begin
        presc_next = pix_tick ? '0 : presc_reg + 1'b1;
    end

    vga_axis_counter #(
        .CNT_W (CNT_W), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL)
    ) u_hor (
        .Clk    (Clk),
        .Reset  (Reset),
        .advance(pix_tick),
        .count  (h_count),
        .wrap   (h_wrap),
        .sync_q (h_sync_q),
        .active (h_active)
    );

    vga_axis_counter #(
        .CNT_W (CNT_W), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL)
    ) u_ver (
        .Clk    (Clk),
        .Reset  (Reset),
        .advance(h_wrap),
        .count  (v_count),
        .wrap   (v_wrap),
        .sync_q (v_sync_q),
        .active (v_active)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            presc_reg     <= '0;
            video_on_reg  <= 1'b0;
            line_end_reg  <= 1'b0;
            frame_end_reg <= 1'b0;
        end else begin
            presc_reg     <= presc_next;
            video_on_reg  <= h_active && v_active;
            line_end_reg  <= h_wrap;
            frame_end_reg <= v_wrap;
        end
    end

    assign vga.cntHorizontal = h_count;
    assign vga.cntVertical   = v_count;
    assign vga.pix_tick      = pix_tick;
    assign vga.hsync         = h_sync_q;
    assign vga.vsync         = v_sync_q;
    assign vga.video_on      = video_on_reg;
    assign vga.line_end      = line_end_reg;
    assign vga.frame_end     = frame_end_reg;

endmodule
